// File: rtl/gw2a_ddr_dq_sched.sv
// rtl/gw2a_ddr_dq_sched.sv - DQ/DQS IOB sequencer: output enables, write fetch, read capture, turnaround spacing
module gw2a_ddr_dq_sched #(
    parameter int WR_LAT   = 5,
    parameter int RD_LAT   = 7,
    parameter int BURST    = 4,
    parameter int WR_TO_RD = 2,
    parameter int RD_TO_WR = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic cmd_valid_i,
    output logic cmd_ready_o,
    input  logic cmd_write_i,
    output logic wr_ready_o,
    input  logic wr_valid_i,
    output logic dq_oen_o,
    output logic dqs_oen_o,
    output logic rd_capture_o,
    output logic rd_last_o,
    output logic busy_o,
    output logic err_underrun_o
);

    localparam int WR_DEPTH   = WR_LAT + BURST;
    localparam int RD_DEPTH   = RD_LAT + BURST - 1;
    localparam int GAP_WR_RAW = WR_LAT + BURST + WR_TO_RD + 1 - RD_LAT;
    localparam int GAP_RW_RAW = RD_LAT + BURST + RD_TO_WR + 1 - WR_LAT;
    // Ready ignores the next command's direction, so each history uses its worst gap.
    localparam int GAP_W      = (GAP_WR_RAW > BURST) ? GAP_WR_RAW : BURST;
    localparam int GAP_R      = (GAP_RW_RAW > BURST) ? GAP_RW_RAW : BURST;
    localparam logic [3:0] NEED_W = 4'(GAP_W);
    localparam logic [3:0] NEED_R = 4'(GAP_R);

    // Bit k set means a command of that direction was accepted k cycles ago.
    logic [WR_DEPTH:1] wr_line;
    logic [RD_DEPTH:1] rd_line;
    logic [3:0]        since_wr;
    logic [3:0]        since_rd;
    logic [3:0]        since_wr_nxt;
    logic [3:0]        since_rd_nxt;
    logic              accept;
    logic              accept_wr;
    logic              accept_rd;

    always_comb begin
        accept       = cmd_valid_i & cmd_ready_o;
        accept_wr    = accept & cmd_write_i;
        accept_rd    = accept & ~cmd_write_i;
        since_wr_nxt = accept_wr ? 4'd1 : ((since_wr == 4'hF) ? since_wr : since_wr + 4'd1);
        since_rd_nxt = accept_rd ? 4'd1 : ((since_rd == 4'hF) ? since_rd : since_rd + 4'd1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_line        <= '0;
            rd_line        <= '0;
            since_wr       <= 4'hF;
            since_rd       <= 4'hF;
            cmd_ready_o    <= 1'b0;
            err_underrun_o <= 1'b0;
        end else begin
            wr_line[1] <= accept_wr;
            for (int i = 2; i <= WR_DEPTH; i++) begin
                wr_line[i] <= wr_line[i-1];
            end
            rd_line[1] <= accept_rd;
            for (int i = 2; i <= RD_DEPTH; i++) begin
                rd_line[i] <= rd_line[i-1];
            end
            since_wr    <= since_wr_nxt;
            since_rd    <= since_rd_nxt;
            cmd_ready_o <= (since_wr_nxt >= NEED_W) && (since_rd_nxt >= NEED_R);
            if (wr_ready_o && !wr_valid_i) begin
                err_underrun_o <= 1'b1;
            end
        end
    end

    // Fetch runs one cycle ahead of drive; DQS adds one preamble and one postamble cycle.
    assign wr_ready_o   = |wr_line[WR_LAT+BURST-2:WR_LAT-1];
    assign dq_oen_o     = ~(|wr_line[WR_LAT+BURST-1:WR_LAT]);
    assign dqs_oen_o    = ~(|wr_line[WR_LAT+BURST:WR_LAT-1]);
    assign rd_capture_o = |rd_line[RD_LAT+BURST-1:RD_LAT];
    assign rd_last_o    = rd_line[RD_LAT+BURST-1];
    assign busy_o       = (|wr_line) | (|rd_line);

endmodule
